// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared constants and writeback request type for the
//                register-file write port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int unsigned BUF_DEPTH_DEF = 2;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned XLEN          = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
        reg_onehot = 32'd1 << rd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous FIFO of writeback requests, asynchronous
//                active-low reset. Head is a registered-state read.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = BUF_DEPTH_DEF,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  wb_req_t          i_wdata,
    input  logic             i_pop,
    output wb_req_t          o_head,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned         PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]    c_LAST = PTR_W'(DEPTH - 1);

    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the register-file write port between the pipeline
//                writeback stage and buffered multi-cycle-unit results, with
//                a pending-register scoreboard driving the decode stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iPipeWeW,
    input  logic [REG_ADDR_W-1:0] iPipeRdW,
    input  logic [XLEN-1:0]       iPipeDataW,
    input  logic                  iMduValid,
    input  logic [REG_ADDR_W-1:0] iMduRd,
    input  logic [XLEN-1:0]       iMduData,
    output logic                  oMduReady,
    input  logic                  iMduIssue,
    input  logic [REG_ADDR_W-1:0] iMduIssueRd,
    input  logic [REG_ADDR_W-1:0] iRs1D,
    input  logic [REG_ADDR_W-1:0] iRs2D,
    input  logic [REG_ADDR_W-1:0] iRdD,
    output logic                  oStallD,
    output logic                  oRegWe,
    output logic [REG_ADDR_W-1:0] oRegRd,
    output logic [XLEN-1:0]       oRegData,
    output logic [CNT_W-1:0]      oBufCount
);

    logic             w_pipe_eff;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    wb_req_t          w_wdata;
    wb_req_t          w_head;
    logic [CNT_W-1:0] w_count;
    logic [31:0]      w_set;
    logic [31:0]      w_clr;
    logic [31:0]      r_pending;

    assign w_pipe_eff = iPipeWeW && (iPipeRdW != '0);

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign oMduReady  = (w_count < CNT_W'(BUF_DEPTH));
    assign w_push     = iMduValid && oMduReady && (iMduRd != '0);
    assign w_pop      = !w_pipe_eff && !w_empty;
    assign w_wdata    = '{rd: iMduRd, data: iMduData};

    wb_fifo #(
        .DEPTH   (BUF_DEPTH)
    ) u_fifo (
        .i_clk   (iClk),
        .i_rst_n (iRstN),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        oRegWe   = 1'b0;
        oRegRd   = '0;
        oRegData = '0;
        if (w_pipe_eff) begin
            oRegWe   = 1'b1;
            oRegRd   = iPipeRdW;
            oRegData = iPipeDataW;
        end else if (!w_empty) begin
            oRegWe   = 1'b1;
            oRegRd   = w_head.rd;
            oRegData = w_head.data;
        end
    end

    assign w_set = (iMduIssue && (iMduIssueRd != '0)) ? reg_onehot(iMduIssueRd) : '0;
    assign w_clr = w_pop ? reg_onehot(w_head.rd) : '0;

    // Set is applied after clear so a re-issue to a retiring register stays pending.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | w_set) & ~32'd1;
        end
    end

    assign oStallD   = r_pending[iRs1D] | r_pending[iRs2D] | r_pending[iRdD];
    assign oBufCount = w_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Directed vector bench for wb_port_arbiter (BUF_DEPTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        iClk;
    logic        iRstN;
    logic        iPipeWeW;
    logic [4:0]  iPipeRdW;
    logic [31:0] iPipeDataW;
    logic        iMduValid;
    logic [4:0]  iMduRd;
    logic [31:0] iMduData;
    logic        oMduReady;
    logic        iMduIssue;
    logic [4:0]  iMduIssueRd;
    logic [4:0]  iRs1D;
    logic [4:0]  iRs2D;
    logic [4:0]  iRdD;
    logic        oStallD;
    logic        oRegWe;
    logic [4:0]  oRegRd;
    logic [31:0] oRegData;
    logic [1:0]  oBufCount;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter #(
        .BUF_DEPTH   (2)
    ) dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .iPipeWeW    (iPipeWeW),
        .iPipeRdW    (iPipeRdW),
        .iPipeDataW  (iPipeDataW),
        .iMduValid   (iMduValid),
        .iMduRd      (iMduRd),
        .iMduData    (iMduData),
        .oMduReady   (oMduReady),
        .iMduIssue   (iMduIssue),
        .iMduIssueRd (iMduIssueRd),
        .iRs1D       (iRs1D),
        .iRs2D       (iRs2D),
        .iRdD        (iRdD),
        .oStallD     (oStallD),
        .oRegWe      (oRegWe),
        .oRegRd      (oRegRd),
        .oRegData    (oRegData),
        .oBufCount   (oBufCount)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        iss;
        logic [4:0]  issrd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic        erdy;
        logic        estall;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int pwe, input int prd, input int pdata,
                                input int mv, input int mrd, input int mdata,
                                input int iss, input int issrd,
                                input int rs1, input int rs2, input int rd,
                                input int ewe, input int erd, input int edata,
                                input int erdy, input int estall, input int ecnt);
        vec_t v;
        v.pwe = 1'(pwe);   v.prd = 5'(prd);    v.pdata = 32'(pdata);
        v.mv  = 1'(mv);    v.mrd = 5'(mrd);    v.mdata = 32'(mdata);
        v.iss = 1'(iss);   v.issrd = 5'(issrd);
        v.rs1 = 5'(rs1);   v.rs2 = 5'(rs2);    v.rd = 5'(rd);
        v.ewe = 1'(ewe);   v.erd = 5'(erd);    v.edata = 32'(edata);
        v.erdy = 1'(erdy); v.estall = 1'(estall); v.ecnt = 2'(ecnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        iPipeWeW = v.pwe;  iPipeRdW = v.prd;  iPipeDataW = v.pdata;
        iMduValid = v.mv;  iMduRd = v.mrd;    iMduData = v.mdata;
        iMduIssue = v.iss; iMduIssueRd = v.issrd;
        iRs1D = v.rs1;     iRs2D = v.rs2;     iRdD = v.rd;
    endtask

    task automatic check_outs(input string tag, input logic ewe, input logic [4:0] erd,
                              input logic [31:0] edata, input logic erdy,
                              input logic estall, input logic [1:0] ecnt);
        chk({tag, ".we"},    32'(oRegWe),    32'(ewe));
        chk({tag, ".rd"},    32'(oRegRd),    32'(erd));
        chk({tag, ".data"},  oRegData,       edata);
        chk({tag, ".ready"}, 32'(oMduReady), 32'(erdy));
        chk({tag, ".stall"}, 32'(oStallD),   32'(estall));
        chk({tag, ".count"}, 32'(oBufCount), 32'(ecnt));
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 1,0,0);

        // Idle port: single MDU result, written one cycle later.
        vecs.push_back(idle);
        vecs.push_back(mk(0,0,0, 1,5,'h1234, 0,0, 0,0,0, 0,0,0,      1,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,      0,0, 0,0,0, 1,5,'h1234, 1,0,1));
        vecs.push_back(idle);
        // Contention: pipeline owns the port, buffer fills, then drains in order.
        vecs.push_back(mk(1,3,'hAAAA, 1,7,'h77, 0,0, 0,0,0, 1,3,'hAAAA, 1,0,0));
        vecs.push_back(mk(1,3,'hAAAB, 1,8,'h88, 0,0, 0,0,0, 1,3,'hAAAB, 1,0,1));
        vecs.push_back(mk(1,3,'hAAAC, 1,9,'h99, 0,0, 0,0,0, 1,3,'hAAAC, 0,0,2));
        vecs.push_back(mk(1,3,'hAAAD, 0,0,0,    0,0, 0,0,0, 1,3,'hAAAD, 0,0,2));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,7,'h77, 0,0,2));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,8,'h88, 1,0,1));
        vecs.push_back(idle);
        // Scoreboard: rd=10 pending through rs1, rs2 and rd lookups.
        vecs.push_back(mk(0,0,0, 0,0,0,     1,10, 10,0,0,   0,0,0,     1,0,0));
        vecs.push_back(mk(0,0,0, 1,10,'h10, 0,0,  0,10,0,   0,0,0,     1,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0,     0,0,  0,0,10,   1,10,'h10, 1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,     0,0,  10,10,10, 0,0,0,     1,0,0));
        // x0 handling.
        vecs.push_back(mk(0,0,0,      1,4,'h44, 0,0, 0,0,0, 0,0,0,     1,0,0));
        vecs.push_back(mk(1,0,'hDEAD, 0,0,0,    0,0, 0,0,0, 1,4,'h44,  1,0,1));
        vecs.push_back(mk(0,0,0,      1,0,'h55, 0,0, 0,0,0, 0,0,0,     1,0,0));
        vecs.push_back(mk(0,5,'hFFFF, 0,0,0,    1,0, 0,0,0, 0,0,0,     1,0,0));
        vecs.push_back(idle);
        // Set/clear collision on rd=12, then a final retire clears it.
        vecs.push_back(mk(0,0,0, 0,0,0,     1,12, 12,0,0, 0,0,0,     1,0,0));
        vecs.push_back(mk(0,0,0, 1,12,'hC,  0,0,  12,0,0, 0,0,0,     1,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0,     1,12, 12,0,0, 1,12,'hC,  1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,     0,0,  12,0,0, 0,0,0,     1,1,0));
        vecs.push_back(mk(0,0,0, 1,12,'hD,  0,0,  12,0,0, 0,0,0,     1,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0,     0,0,  12,0,0, 1,12,'hD,  1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,     0,0,  12,0,0, 0,0,0,     1,0,0));

        iRstN = 1'b0;
        drive(idle);
        #3;
        check_outs("reset", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 2'd0);
        @(negedge iClk);
        iRstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge iClk);
            #1;
            drive(vecs[i]);
            @(negedge iClk);
            check_outs($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].erd, vecs[i].edata,
                       vecs[i].erdy, vecs[i].estall, vecs[i].ecnt);
        end

        // Asynchronous reset with two buffered entries and two pending bits.
        @(posedge iClk); #1;
        drive(mk(1,3,'hB0, 1,20,'hA0, 1,20, 0,0,0, 0,0,0, 0,0,0));
        @(posedge iClk); #1;
        drive(mk(1,3,'hB1, 1,21,'hA1, 1,21, 0,0,0, 0,0,0, 0,0,0));
        @(posedge iClk); #1;
        drive(mk(1,3,'hB2, 0,0,0, 0,0, 20,21,0, 0,0,0, 0,0,0));
        @(negedge iClk);
        check_outs("prerst", 1'b1, 5'd3, 32'hB2, 1'b0, 1'b1, 2'd2);
        #1;
        iRstN = 1'b0;
        #1;
        check_outs("inrst_pipe", 1'b1, 5'd3, 32'hB2, 1'b1, 1'b0, 2'd0);
        iPipeWeW = 1'b0;
        #1;
        check_outs("inrst_idle", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 2'd0);
        @(posedge iClk); #1;
        iRstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            check_outs($sformatf("postrst%0d", i), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 2'd0);
            @(posedge iClk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
